// File: rtl/uart_alu_host.sv
// Host side of the UART ALU link. Sends operand A, operand B and the opcode
// as three back-to-back 8N1 frames, then waits for one result frame or a timeout.
// Ports:
//   i_clock, i_reset      clock, asynchronous active-high reset
//   i_start               transaction request (sampled only in IDLE)
//   i_a, i_b, i_op        operands and opcode, latched at acceptance
//   i_rx / o_tx           serial lines, both idle high
//   o_busy                high from acceptance until back in IDLE
//   o_result              last good result, held until overwritten
//   o_result_valid        one-cycle pulse when o_result updates
//   o_timeout             one-cycle pulse when no response arrived in time
//   o_frame_err           one-cycle pulse when the response stop bit was 0
module uart_alu_host #(
    parameter int unsigned DATA_SIZE    = 8,
    parameter int unsigned OPCODE_SIZE  = 6,
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned BAUDRATE     = 19200,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [DATA_SIZE-1:0]   i_a,
    input  logic [DATA_SIZE-1:0]   i_b,
    input  logic [OPCODE_SIZE-1:0] i_op,
    input  logic                   i_rx,
    output logic                   o_tx,
    output logic                   o_busy,
    output logic [DATA_SIZE-1:0]   o_result,
    output logic                   o_result_valid,
    output logic                   o_timeout,
    output logic                   o_frame_err
);

    localparam int unsigned TDIV     = CLK_HZ / (BAUDRATE * 16);
    localparam int unsigned TW       = (TDIV > 1) ? $clog2(TDIV) : 1;
    localparam int unsigned BW       = $clog2(DATA_SIZE + 2);
    localparam int unsigned TO_LIMIT = TIMEOUT_BITS * 16;
    localparam int unsigned OW       = $clog2(TO_LIMIT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_A,
        ST_SEND_B,
        ST_SEND_OP,
        ST_WAIT_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [3:0]             sub_q, sub_d;        // tick within bit (tx and rx share it)
    logic [BW-1:0]          bit_q, bit_d;        // 0 = start, 1..DATA_SIZE = data, last = stop
    logic [DATA_SIZE-1:0]   sh_q, sh_d;          // tx shift register
    logic [DATA_SIZE-1:0]   b_q, b_d;
    logic [DATA_SIZE-1:0]   op_q, op_d;
    logic [DATA_SIZE-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_SIZE-1:0]   result_q, result_d;
    logic [OW-1:0]          to_q, to_d;
    logic                   rx_act_q, rx_act_d;  // start bit seen, frame in progress
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;
    logic                   ferr_q, ferr_d;
    logic                   rx_meta_q, rx_sync_q;
    logic                   tick;
    logic [OW-1:0]          to_inc;

    // State and datapath registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            sub_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            b_q        <= '0;
            op_q       <= '0;
            rx_sh_q    <= '0;
            result_q   <= '0;
            to_q       <= '0;
            rx_act_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            ferr_q     <= 1'b0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            sub_q      <= sub_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            b_q        <= b_d;
            op_q       <= op_d;
            rx_sh_q    <= rx_sh_d;
            result_q   <= result_d;
            to_q       <= to_d;
            rx_act_q   <= rx_act_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            ferr_q     <= ferr_d;
            rx_meta_q  <= i_rx;
            rx_sync_q  <= rx_meta_q;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        sub_d      = sub_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        b_d        = b_q;
        op_d       = op_q;
        rx_sh_d    = rx_sh_q;
        result_d   = result_q;
        to_d       = to_q;
        rx_act_d   = rx_act_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        timeout_d  = 1'b0;
        ferr_d     = 1'b0;
        tick       = (tick_cnt_q == TW'(TDIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        to_inc     = (to_q == OW'(TO_LIMIT)) ? to_q : to_q + OW'(1);

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d    = ST_SEND_A;
                    tick_cnt_d = '0;     // aligns o_tx edges to the acceptance edge
                    sub_d      = '0;
                    bit_d      = '0;
                    sh_d       = i_a;
                    b_d        = i_b;
                    op_d       = DATA_SIZE'(i_op);
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            ST_SEND_A, ST_SEND_B, ST_SEND_OP: begin
                if (tick) begin
                    if (sub_q == 4'd15) begin
                        sub_d = '0;
                        if (bit_q == BW'(DATA_SIZE + 1)) begin
                            // Stop bit done: next frame starts immediately
                            bit_d = '0;
                            if (state_q == ST_SEND_A) begin
                                state_d = ST_SEND_B;
                                sh_d    = b_q;
                                tx_d    = 1'b0;
                            end else if (state_q == ST_SEND_B) begin
                                state_d = ST_SEND_OP;
                                sh_d    = op_q;
                                tx_d    = 1'b0;
                            end else begin
                                state_d  = ST_WAIT_RESP;
                                tx_d     = 1'b1;
                                to_d     = '0;
                                rx_act_d = 1'b0;
                            end
                        end else begin
                            bit_d = bit_q + BW'(1);
                            if (bit_q == BW'(DATA_SIZE)) begin
                                tx_d = 1'b1;
                            end else begin
                                tx_d = sh_q[0];
                                sh_d = sh_q >> 1;
                            end
                        end
                    end else begin
                        sub_d = sub_q + 4'd1;
                    end
                end
            end

            ST_WAIT_RESP: begin
                if (tick) begin
                    if (!rx_act_q) begin
                        // Hunting; a start edge takes priority over expiry
                        if (!rx_sync_q) begin
                            rx_act_d = 1'b1;
                            sub_d    = '0;
                            bit_d    = '0;
                            to_d     = to_inc;
                        end else if (to_q >= OW'(TO_LIMIT - 1)) begin
                            timeout_d = 1'b1;
                            busy_d    = 1'b0;
                            state_d   = ST_IDLE;
                        end else begin
                            to_d = to_inc;
                        end
                    end else if (bit_q == '0) begin
                        // Start verification window: timeout keeps counting
                        to_d = to_inc;
                        if (sub_q == 4'd6) begin
                            sub_d = '0;
                            if (rx_sync_q) begin
                                rx_act_d = 1'b0;
                            end else begin
                                bit_d = BW'(1);
                            end
                        end else begin
                            sub_d = sub_q + 4'd1;
                        end
                    end else if (sub_q == 4'd15) begin
                        sub_d = '0;
                        if (bit_q == BW'(DATA_SIZE + 1)) begin
                            state_d  = ST_IDLE;
                            busy_d   = 1'b0;
                            rx_act_d = 1'b0;
                            if (rx_sync_q) begin
                                result_d = rx_sh_q;
                                valid_d  = 1'b1;
                            end else begin
                                ferr_d = 1'b1;
                            end
                        end else begin
                            rx_sh_d = {rx_sync_q, rx_sh_q[DATA_SIZE-1:1]};
                            bit_d   = bit_q + BW'(1);
                        end
                    end else begin
                        sub_d = sub_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign o_tx           = tx_q;
    assign o_busy         = busy_q;
    assign o_result       = result_q;
    assign o_result_valid = valid_q;
    assign o_timeout      = timeout_q;
    assign o_frame_err    = ferr_q;

endmodule
